cache_pmem_arbiter: RTL

Shares the single physical-memory line port between the I-cache and D-cache miss paths of the pipelined CPU. The I-side is read-only and the D-side is read/write.
- Grants one requester at a time and locks the grant until pmem_resp.
- Holds address, command and write data stable in registers for the whole transaction.
- Steers the response and line data back to the granted cache only.
- Sits between the two caches and main memory, below cpu_datapath's imem/dmem interfaces.

---
 rtl/arb_types.sv | 18 +
 rtl/cache_pmem_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/arb_types.sv
// Shared types for the I/D cache physical-memory arbiter.
package arb_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I,
    ARB_D,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  localparam int DEF_LINE_WIDTH = 256;

endpackage

// File: rtl/cache_pmem_arbiter.sv
// Shares one pmem line port between I-cache and D-cache miss paths.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention.
module cache_pmem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            state_q, state_d;
  arb_src_t              last_grant_q, last_grant_d;
  logic                  pmem_read_q, pmem_read_d;
  logic                  pmem_write_q, pmem_write_d;
  logic [ADDR_WIDTH-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  // under contention, hand the port to the side not served last
  assign grant_d = d_req &
                   (~i_req | (last_grant_q == SRC_I));
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d        = ARB_D;
          pmem_address_d = d_pmem_address;
          pmem_wdata_d   = d_pmem_wdata;
          pmem_write_d   = d_pmem_write;
          pmem_read_d    = ~d_pmem_write;
        end else if (i_req) begin
          state_d        = ARB_I;
          pmem_address_d = i_pmem_address;
          pmem_wdata_d   = '0;
          pmem_write_d   = 1'b0;
          pmem_read_d    = 1'b1;
        end
      end
      ARB_I: begin
        if (pmem_resp) begin
          state_d      = ARB_DONE;
          last_grant_d = SRC_I;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      ARB_D: begin
        if (pmem_resp) begin
          state_d      = ARB_DONE;
          last_grant_d = SRC_D;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      last_grant_q   <= SRC_I;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // response is steered only while the matching side holds the grant
  assign i_pmem_resp  = pmem_resp & (state_q == ARB_I);
  assign d_pmem_resp  = pmem_resp & (state_q == ARB_D);
  assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule
